// File: rtl/seq_detect_param.sv
// seq_detect_param: serial sequence detector with a pattern that can be loaded at run time.
//
// The detector compares the last PAT_W accepted bits of a 1-bit stream with a
// stored pattern. The match flag z is combinational (Mealy timing), so it rises
// in the same cycle as the bit that completes the pattern. Detection can be
// overlapping or non-overlapping, and this is chosen at load time. A saturating
// counter counts the matches.
//
// Optional build feature, enabled by defining SEQ_DETECT_MASK_EN:
//   - adds the mask_in port;
//   - mask_q is latched on load;
//   - pattern bits whose mask bit is 0 are don't-care.
// Without the macro, every pattern bit takes part in the compare.
//
// Bit ordering: pattern bit PAT_W-1 is the oldest received bit and bit 0 is the
// newest one. The compare window {hist, x} uses the same ordering.

module seq_detect_param #(
    parameter int                 PAT_W   = 4,
    parameter logic [PAT_W-1:0]   PAT_RST = PAT_W'(4'b1001),
    parameter int                 CNT_W   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  x,
    input  logic                  x_valid,
    input  logic                  load,
    input  logic [PAT_W-1:0]      pattern_in,
    input  logic                  overlap_in,
    input  logic                  cnt_clr,
`ifdef SEQ_DETECT_MASK_EN
    input  logic [PAT_W-1:0]      mask_in,
`endif
    output logic                  z,
    output logic [CNT_W-1:0]      match_count,
    output logic                  cnt_sat
);

    // The fill counter must reach PAT_W-1, which needs ceil(log2(PAT_W)) bits.
    localparam int               FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    // A bit matches when it is equal to the pattern bit or when its mask bit is 0.
    function automatic logic pattern_hit(
        input logic [PAT_W-1:0] window,
        input logic [PAT_W-1:0] pat,
        input logic [PAT_W-1:0] mask
    );
        return (((window ^ pat) & mask) == {PAT_W{1'b0}});
    endfunction

    // Configuration registers.
    logic [PAT_W-1:0]   pat_r;
    logic               overlap_r;
    logic [PAT_W-1:0]   mask_s;

    // History registers: the PAT_W-1 previous accepted bits, and how many of
    // them are valid.
    logic [PAT_W-2:0]   hist_r;
    logic [FILL_W-1:0]  fill_r;

    // Match counter.
    logic [CNT_W-1:0]   match_count_r;
    logic               cnt_sat_r;
    logic [CNT_W-1:0]   cnt_next_s;

    // Compare path signals.
    logic [PAT_W-1:0]   window_s;
    logic               accept_s;
    logic               full_s;
    logic               hit_s;
    logic               z_s;

`ifdef SEQ_DETECT_MASK_EN
    logic [PAT_W-1:0]   mask_r;

    // The mask is latched together with the pattern. Its reset value, all
    // ones, makes every pattern bit significant.
    always_ff @(posedge clock) begin
        if (reset) begin
            mask_r <= {PAT_W{1'b1}};
        end else if (load) begin
            mask_r <= mask_in;
        end else begin
            mask_r <= mask_r;
        end
    end

    assign mask_s = mask_r;
`else
    assign mask_s = {PAT_W{1'b1}};
`endif

    // Pattern and overlap mode. They come back to the built-in defaults on
    // reset, even after a load.
    always_ff @(posedge clock) begin
        if (reset) begin
            pat_r     <= PAT_RST;
            overlap_r <= 1'b1;
        end else if (load) begin
            pat_r     <= pattern_in;
            overlap_r <= overlap_in;
        end else begin
            pat_r     <= pat_r;
            overlap_r <= overlap_r;
        end
    end

    // Build the compare window and the Mealy match flag. This path has no
    // register between x and z.
    always_comb begin
        window_s = {hist_r, x};
        accept_s = x_valid & ~load & ~reset;
        full_s   = (fill_r >= FILL_MAX);
        hit_s    = pattern_hit(window_s, pat_r, mask_s);
        z_s      = accept_s & full_s & hit_s;
    end

    assign z = z_s;

    // Shift history on accepted bits. A load restarts the history. A
    // non-overlapping match also restarts it, by clearing fill, so that the
    // next match needs PAT_W fresh bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist_r <= {(PAT_W-1){1'b0}};
            fill_r <= {FILL_W{1'b0}};
        end else if (load) begin
            hist_r <= {(PAT_W-1){1'b0}};
            fill_r <= {FILL_W{1'b0}};
        end else if (x_valid) begin
            hist_r <= window_s[PAT_W-2:0];
            if (z_s && !overlap_r) begin
                fill_r <= {FILL_W{1'b0}};
            end else if (fill_r != FILL_MAX) begin
                fill_r <= fill_r + FILL_W'(1);
            end else begin
                fill_r <= fill_r;
            end
        end else begin
            hist_r <= hist_r;
            fill_r <= fill_r;
        end
    end

    // Next count value. A clear wins over a match in the same cycle, and the
    // count stops at all ones.
    always_comb begin
        cnt_next_s = match_count_r;
        if (cnt_clr) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (z_s && (match_count_r != CNT_MAX)) begin
            cnt_next_s = match_count_r + CNT_W'(1);
        end else begin
            cnt_next_s = match_count_r;
        end
    end

    // Register the count. The saturation flag is computed from the next value,
    // so it is high in the same cycle as the all-ones count.
    always_ff @(posedge clock) begin
        if (reset) begin
            match_count_r <= {CNT_W{1'b0}};
            cnt_sat_r     <= 1'b0;
        end else begin
            match_count_r <= cnt_next_s;
            cnt_sat_r     <= (cnt_next_s == CNT_MAX);
        end
    end

    assign match_count = match_count_r;
    assign cnt_sat     = cnt_sat_r;

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial sequence detector. It generalises the fixed 4-state "1001" Mealy detector to a run-time-loadable pattern of PAT_W bits, with selectable overlapping or non-overlapping detection, an input qualifier, and a saturating match counter. It sits on a 1-bit serial input stream and flags pattern completion combinationally on the completing bit (Mealy timing).

Parameters:
PAT_W, 4, pattern length in bits; legal range 2..16.
PAT_RST, 4'b1001, pattern value held after reset; width PAT_W.
CNT_W, 8, width of the match counter.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
x  input  1  serial data bit.
x_valid  input  1  x is sampled only when high.
load  input  1  one-cycle strobe that latches pattern_in and overlap_in.
pattern_in  input  PAT_W  new pattern; bit PAT_W-1 is the first (oldest) bit received, bit 0 is the last.
overlap_in  input  1  1 = overlapping detection, 0 = non-overlapping.
cnt_clr  input  1  clears match_count.
z  output  1  Mealy match flag, combinational.
match_count  output  CNT_W  number of matches, saturating.
cnt_sat  output  1  high while match_count equals all ones.

Behaviour:
- Reset: reset, synchronous, active-high; clock clock.
- Values on reset:
  - pat_q = PAT_RST; overlap_q = 1.
  - History register hist (PAT_W-1 bits) = 0; fill counter = 0.
  - match_count = 0; cnt_sat = 0.
  - z = 0 during the reset cycle.
- Match condition:
  - z = x_valid & !load & !reset & (fill >= PAT_W-1) & ({hist, x} == pat_q).
  - Zero latency: z is asserted in the same cycle as the completing bit.
  - No register sits between x and z.
- Accepting a bit: on a clock edge with x_valid=1 and load=0:
  - hist <= {hist[PAT_W-3:0], x}.
  - fill increments, saturating at PAT_W-1.
- Overlap handling when z=1:
  - overlap_q=1: history is kept. The suffix can start the next match; for example, with pattern 1001 the input 1001001 matches twice.
  - overlap_q=0: fill <= 0, so the next match needs PAT_W fresh bits. The same input 1001001 then matches once.
- x_valid=0: hist, fill and z hold, and z=0. Gaps in x_valid do not break a sequence in progress.
- Load:
  - On a clock edge with load=1: pat_q <= pattern_in, overlap_q <= overlap_in, fill <= 0, hist <= 0.
  - load takes priority over x_valid in the same cycle. The bit is discarded and z=0.
  - The new pattern applies from the next cycle.
- Match counter:
  - On each edge with z=1, match_count increments, saturating at 2^CNT_W-1.
  - cnt_sat is registered and high when match_count is all ones.
  - cnt_clr=1 clears the counter to 0. If cnt_clr and z are both high in the same cycle, the counter ends at 0 (clear wins).
  - cnt_clr does not affect hist, fill or pat_q.
- Reset mid-sequence: all state returns to reset values and any partial match is lost. The pattern reverts to PAT_RST even if one was loaded.
- Widths: fill counter is ceil(log2(PAT_W)) bits. Comparison is full-width and unsigned.

Optional Feature:
SEQ_DETECT_MASK_EN
- Defined:
  - Adds input port mask_in (width PAT_W), latched into mask_q on load. mask_q resets to all ones.
  - The compare becomes ((({hist, x}) ^ pat_q) & mask_q) == 0. Bits where mask_q is 0 are don't-care.
  - A mask of all zeros matches every accepted bit once fill >= PAT_W-1.
- Not defined:
  - No mask_in port, no mask_q register.
  - Behaviour equals mask all ones.

Test Plan:
- Reset, default pattern 1001, overlap on, x_valid=1, x stream 1,0,0,1,0,0,1 → z=1 on the 4th and 7th bits; match_count=2.
- load with pattern_in=1001, overlap_in=0, then stream 1,0,0,1,0,0,1 → z=1 on the 4th bit only; match_count=1.
- Stream 1,0 then x_valid=0 for 3 cycles, then 0,1 → z=0 during the gap; z=1 on the final bit.
- Stream 1,0,0, then load asserted together with x=1 and x_valid=1 → z=0 that cycle; fill=0 afterwards; the next stream 1,0,0,1 matches on its 4th bit.
- CNT_W=2, 4 overlapping matches → match_count saturates at 3; cnt_sat=1. Next, cnt_clr together with a match → match_count=0.
- With SEQ_DETECT_MASK_EN: pattern 1001, mask 1011, stream 1,1,0,1 → z=1; with mask 1111 the same stream → z=0.
